// File: rtl/sprite_fetch_unit.sv
// Sprite ROM address generator and colour qualifier: double-buffered position, 2-edge fixed latency.
// Define SPRITE_BLINK_EN to add a frame-counted blink that hides the sprite on alternate periods.
module sprite_fetch_unit #(
    parameter int          SPRITE_W    = 32,
    parameter int          SPRITE_H    = 32,
    parameter int          DEFAULT_X   = 0,
    parameter int          DEFAULT_Y   = 0,
    parameter logic [23:0] TRANSPARENT = 24'hFFFFFF
`ifdef SPRITE_BLINK_EN
    ,
    parameter int          BLINK_FRAMES = 30
`endif
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_start,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        enable,
    input  logic        pos_wr,
    input  logic [9:0]  pos_x_in,
    input  logic [9:0]  pos_y_in,
    output logic [18:0] read_address,
    input  logic [23:0] rom_data,
    output logic [23:0] pixel_color,
    output logic        pixel_hit
);

    logic [9:0]  pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic [9:0]  cx_q, cx_d, cy_q, cy_d;
    logic [18:0] read_address_q, read_address_d;
    logic        hit1_q, hit1_d, hit2_q, hit2_d;
    logic [23:0] pixel_color_q, pixel_color_d;
    logic        pixel_hit_q, pixel_hit_d;

    logic [10:0] x11, y11, cx11, cy11, right11, bottom11, dx, dy;
    logic        visible;
    logic        in_box;

`ifdef SPRITE_BLINK_EN
    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [CW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_hidden_q, blink_hidden_d;

    always_comb begin
        blink_cnt_d    = blink_cnt_q;
        blink_hidden_d = blink_hidden_q;
        if (!enable) begin
            blink_cnt_d    = '0;
            blink_hidden_d = 1'b0;
        end else if (frame_start) begin
            if (blink_cnt_q == CW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d    = '0;
                blink_hidden_d = ~blink_hidden_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            blink_cnt_q    <= '0;
            blink_hidden_q <= 1'b0;
        end else begin
            blink_cnt_q    <= blink_cnt_d;
            blink_hidden_q <= blink_hidden_d;
        end
    end

    assign visible = ~blink_hidden_q;
`else
    assign visible = 1'b1;
`endif

    always_comb begin
        pend_x_d = pend_x_q;
        pend_y_d = pend_y_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        if (pos_wr) begin
            pend_x_d = pos_x_in;
            pend_y_d = pos_y_in;
        end
        // Committed position only moves at frame start; a same-cycle write bypasses the pending copy.
        if (frame_start) begin
            cx_d = pos_wr ? pos_x_in : pend_x_q;
            cy_d = pos_wr ? pos_y_in : pend_y_q;
        end
    end

    always_comb begin
        x11      = {1'b0, DrawX};
        y11      = {1'b0, DrawY};
        cx11     = {1'b0, cx_q};
        cy11     = {1'b0, cy_q};
        // 11-bit right/bottom edges so a sprite near the screen edge clips instead of wrapping.
        right11  = cx11 + 11'(SPRITE_W);
        bottom11 = cy11 + 11'(SPRITE_H);
        dx       = x11 - cx11;
        dy       = y11 - cy11;
        in_box   = enable && visible &&
                   (x11 >= cx11) && (x11 < right11) &&
                   (y11 >= cy11) && (y11 < bottom11);

        read_address_d = in_box ? (19'(dy) * 19'(SPRITE_W) + 19'(dx)) : 19'd0;
        hit1_d         = in_box;
        hit2_d         = hit1_q;
        pixel_color_d  = hit2_q ? rom_data : 24'd0;
        pixel_hit_d    = hit2_q && (rom_data != TRANSPARENT);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pend_x_q       <= 10'(DEFAULT_X);
            pend_y_q       <= 10'(DEFAULT_Y);
            cx_q           <= 10'(DEFAULT_X);
            cy_q           <= 10'(DEFAULT_Y);
            read_address_q <= '0;
            hit1_q         <= 1'b0;
            hit2_q         <= 1'b0;
            pixel_color_q  <= '0;
            pixel_hit_q    <= 1'b0;
        end else begin
            pend_x_q       <= pend_x_d;
            pend_y_q       <= pend_y_d;
            cx_q           <= cx_d;
            cy_q           <= cy_d;
            read_address_q <= read_address_d;
            hit1_q         <= hit1_d;
            hit2_q         <= hit2_d;
            pixel_color_q  <= pixel_color_d;
            pixel_hit_q    <= pixel_hit_d;
        end
    end

    assign read_address = read_address_q;
    assign pixel_color  = pixel_color_q;
    assign pixel_hit    = pixel_hit_q;

endmodule

// File: tb/tb_sprite_fetch_unit.sv
// Scoreboard bench for sprite_fetch_unit: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_sprite_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0;
    logic        enable = 1'b0;
    logic        pos_wr = 1'b0;
    logic [9:0]  pos_x_in = '0, pos_y_in = '0;
    logic [18:0] read_address;
    logic [23:0] rom_data = '0;
    logic [23:0] pixel_color;
    logic        pixel_hit;

    sprite_fetch_unit dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .enable(enable),
        .pos_wr(pos_wr), .pos_x_in(pos_x_in), .pos_y_in(pos_y_in),
        .read_address(read_address), .rom_data(rom_data),
        .pixel_color(pixel_color), .pixel_hit(pixel_hit)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int          cyc;
        logic [18:0] addr;
        logic [23:0] color;
        logic        hit;
    } exp_t;

    exp_t qa[$];
    exp_t qp[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    int   mcx = 0, mcy = 0, mpx = 0, mpy = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    // ROM contents: every address with low bits 11 is the transparent key.
    function automatic logic [23:0] rom_fn(logic [18:0] a);
        if (a[1:0] == 2'b11) return 24'hFFFFFF;
        return {5'd0, a};
    endfunction

    always @(posedge Clk) rom_data <= rom_fn(read_address);

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, required %h (cycle %0d)", name, got, want, cyc);
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (Reset_n) begin
            if (qa.size() > 0 && qa[0].cyc <= cyc) begin
                e = qa.pop_front();
                chk("read_address", 32'(read_address), 32'(e.addr));
            end
            if (qp.size() > 0 && qp[0].cyc + 2 <= cyc) begin
                e = qp.pop_front();
                chk("pixel_color", 32'(pixel_color), 32'(e.color));
                chk("pixel_hit", 32'(pixel_hit), 32'(e.hit));
            end
        end
    end

    task automatic drive(int x, int y, logic en);
        exp_t e;
        logic inb;
        @(posedge Clk); #1;
        DrawX  = 10'(x);
        DrawY  = 10'(y);
        enable = en;
        inb = en && x >= mcx && x < mcx + 32 && y >= mcy && y < mcy + 32;
        e.cyc   = cyc + 1;
        e.addr  = inb ? 19'((y - mcy) * 32 + (x - mcx)) : 19'd0;
        e.color = inb ? rom_fn(e.addr) : 24'd0;
        e.hit   = inb && (e.color != 24'hFFFFFF);
        qa.push_back(e);
        qp.push_back(e);
    endtask

    task automatic frame(logic wr, int x, int y);
        @(posedge Clk); #1;
        frame_start = 1'b1;
        pos_wr      = wr;
        pos_x_in    = 10'(x);
        pos_y_in    = 10'(y);
        @(posedge Clk); #1;
        frame_start = 1'b0;
        pos_wr      = 1'b0;
        if (wr) begin
            mpx = x; mpy = y; mcx = x; mcy = y;
        end else begin
            mcx = mpx; mcy = mpy;
        end
    endtask

    task automatic write_pos(int x, int y);
        @(posedge Clk); #1;
        pos_wr   = 1'b1;
        pos_x_in = 10'(x);
        pos_y_in = 10'(y);
        @(posedge Clk); #1;
        pos_wr = 1'b0;
        mpx = x; mpy = y;
    endtask

    task automatic scan(int y, int x0, int x1, logic en);
        for (int x = x0; x <= x1; x++) drive(x, y, en);
    endtask

    initial begin
        int budget;
        #12;
        chk("reset read_address", 32'(read_address), 0);
        chk("reset pixel_color", 32'(pixel_color), 0);
        chk("reset pixel_hit", 32'(pixel_hit), 0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;

        frame(1'b0, 0, 0);
        scan(0, 0, 40, 1'b1);

        write_pos(100, 50);
        scan(20, 0, 40, 1'b1);
        frame(1'b0, 0, 0);
        scan(50, 95, 135, 1'b1);
        scan(20, 0, 35, 1'b1);

        frame(1'b1, 200, 10);
        drive(205, 12, 1'b1);
        scan(12, 198, 202, 1'b1);

        frame(1'b1, 620, 40);
        scan(45, 615, 639, 1'b1);
        scan(45, 0, 11, 1'b1);

        scan(45, 620, 627, 1'b0);
        scan(40, 620, 623, 1'b1);

        // Reset asserted while inside the box: outputs must clear immediately.
        scan(41, 624, 630, 1'b1);
        @(posedge Clk); #3;
        qa.delete();
        qp.delete();
        Reset_n = 1'b0;
        #1;
        chk("midreset read_address", 32'(read_address), 0);
        chk("midreset pixel_color", 32'(pixel_color), 0);
        chk("midreset pixel_hit", 32'(pixel_hit), 0);
        mcx = 0; mcy = 0; mpx = 0; mpy = 0;
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        scan(3, 0, 35, 1'b1);

        budget = 0;
        while ((qa.size() + qp.size()) > 0 && budget < 20) begin
            @(posedge Clk);
            budget++;
        end
        @(negedge Clk);
        chk("scoreboard drained", 32'(qa.size() + qp.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
